// File: rtl/doodle_gait_sequencer.sv
// doodle_gait_sequencer: walking-gait controller for the doodle robot.
// Holds off for calibration after reset, steps the shared leg-ROM address
// at a fixed rate, and picks the gait table from the IR sensors at
// gait-cycle boundaries. Falls into a spin search when the line is lost.
module doodle_gait_sequencer #(
    parameter int STEP_TICKS  = 600000,
    parameter int INIT_TICKS  = 20000000,
    parameter int STEPS       = 16,
    parameter int LOST_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       run_i,
    input  logic       l_ir_i,
    input  logic       r_ir_i,
    output logic [7:0] addr_o,
    output logic       l_en_o,
    output logic       r_en_o,
    output logic       c_en_o,
    output logic       step_tick_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_IDLE   = 2'd1,
        S_WALK   = 2'd2,
        S_SEARCH = 2'd3
    } state_e;

    localparam logic [1:0] G_FWD  = 2'd0;
    localparam logic [1:0] G_TL   = 2'd1;
    localparam logic [1:0] G_TR   = 2'd2;
    localparam logic [1:0] G_SPIN = 2'd3;

    localparam int IW = (INIT_TICKS > 1) ? $clog2(INIT_TICKS) : 1;
    localparam int PW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam int LW = $clog2(LOST_CYCLES + 1);

    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_TICKS - 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(STEP_TICKS - 1);
    localparam logic [5:0]    STEP_LAST = 6'(STEPS - 1);
    localparam logic [LW-1:0] LOST_MAX  = LW'(LOST_CYCLES);

    state_e        state_q, state_d;
    logic [IW-1:0] init_q, init_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [5:0]    step_q, step_d;
    logic [1:0]    gait_q, gait_d;
    logic [LW-1:0] lost_q, lost_d;
    logic          tick_q, tick_d;

    logic          sens_lost;
    logic [1:0]    sens_gait;
    logic [LW-1:0] lost_inc;
    logic          active;

    // Sensor decode; a lost line maps to FWD so IDLE->WALK has a sane default.
    always_comb begin
        sens_lost = ~l_ir_i & ~r_ir_i;
        if (l_ir_i && r_ir_i) sens_gait = G_FWD;
        else if (l_ir_i)      sens_gait = G_TL;
        else if (r_ir_i)      sens_gait = G_TR;
        else                  sens_gait = G_FWD;
    end

    // State and datapath registers, all cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_INIT;
            init_q  <= '0;
            pre_q   <= '0;
            step_q  <= '0;
            gait_q  <= G_FWD;
            lost_q  <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
            pre_q   <= pre_d;
            step_q  <= step_d;
            gait_q  <= gait_d;
            lost_q  <= lost_d;
            tick_q  <= tick_d;
        end
    end

    // Next-state logic: calibration hold, prescaler/step counter, gait choice.
    always_comb begin
        state_d  = state_q;
        init_d   = init_q;
        pre_d    = pre_q;
        step_d   = step_q;
        gait_d   = gait_q;
        lost_d   = lost_q;
        tick_d   = 1'b0;
        lost_inc = lost_q + LW'(1);

        case (state_q)
            S_INIT: begin
                if (init_q == INIT_LAST) begin
                    state_d = S_IDLE;
                    init_d  = '0;
                end else begin
                    init_d = init_q + IW'(1);
                end
            end

            S_IDLE: begin
                pre_d  = '0;
                step_d = '0;
                lost_d = '0;
                gait_d = G_FWD;
                if (run_i) begin
                    state_d = S_WALK;
                    gait_d  = sens_gait;
                end
            end

            default: begin // S_WALK, S_SEARCH
                if (!run_i) begin
                    // Parking beats any boundary on the same edge.
                    state_d = S_IDLE;
                    pre_d   = '0;
                    step_d  = '0;
                    gait_d  = G_FWD;
                    lost_d  = '0;
                end else if (pre_q == PRE_LAST) begin
                    pre_d  = '0;
                    tick_d = 1'b1;
                    if (step_q == STEP_LAST) begin
                        // Gait-cycle boundary: the only place sensors matter.
                        step_d = '0;
                        if (state_q == S_WALK) begin
                            if (!sens_lost) begin
                                gait_d = sens_gait;
                                lost_d = '0;
                            end else if (lost_inc >= LOST_MAX) begin
                                state_d = S_SEARCH;
                                gait_d  = G_SPIN;
                                lost_d  = '0;
                            end else begin
                                lost_d = lost_inc;
                            end
                        end else if (!sens_lost) begin
                            state_d = S_WALK;
                            gait_d  = sens_gait;
                            lost_d  = '0;
                        end
                    end else begin
                        step_d = step_q + 6'd1;
                    end
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
        endcase
    end

    // Outputs decode only registered state; no input reaches them combinationally.
    always_comb begin
        active      = (state_q == S_WALK) || (state_q == S_SEARCH);
        addr_o      = {gait_q, step_q};
        l_en_o      = active && (gait_q != G_TR);
        r_en_o      = active && (gait_q != G_TL);
        c_en_o      = active;
        step_tick_o = tick_q;
        state_o     = state_q;
    end

endmodule

// File: doc/doodle_gait_sequencer.md
# doodle_gait_sequencer

Sequences the doodle robot's walking gait and decides which gait table the leg ROMs play. It replaces the free-running speed prescaler, step counter and power-up timer/flip-flop with one controller:
- Holds off for a calibration interval after reset.
- Steps through gait tables at a fixed rate.
- Picks forward/turn gaits from the debounced IR sensors, only at gait-cycle boundaries.
- Falls into a spin search when the line is lost.

It drives the address bus shared by the three leg ROMs and the enable inputs of the three servo PWM blocks.

## Interface
- STEP_TICKS, 600000: clk cycles per gait step.
- INIT_TICKS, 20000000: clk cycles of calibration hold after reset release.
- STEPS, 16: steps per gait cycle, range 2..64.
- LOST_CYCLES, 4: consecutive boundaries with both sensors at 0 before SEARCH, range ≥1.

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  walk enable (switch). 0 parks the robot.
- l_ir  in  1  debounced left sensor, 1 = line seen. Already synchronous to clk.
- r_ir  in  1  debounced right sensor, 1 = line seen.
- addr  out  8  ROM address {gait[1:0], step[5:0]}.
- l_en  out  1  left servo enable_mov.
- r_en  out  1  right servo enable_mov.
- c_en  out  1  center servo enable_mov.
- step_tick  out  1  one-cycle pulse on every step advance.
- state  out  2  FSM state, for LEDs: 0 INIT, 1 IDLE, 2 WALK, 3 SEARCH.

## Operation
- Gait codes:
  - 0 FWD: l_en=1, r_en=1.
  - 1 TURN_L: l_en=1, r_en=0.
  - 2 TURN_R: l_en=0, r_en=1.
  - 3 SPIN: l_en=1, r_en=1.
- c_en=1 in WALK and SEARCH. All enables are 0 in INIT and IDLE.
- Sensor decode: {l_ir,r_ir}=11 → FWD, 10 → TURN_L, 01 → TURN_R, 00 → lost.
- INIT: init counter counts 0..INIT_TICKS-1, then → IDLE. run is ignored.
- IDLE: prescaler=0, step=0, lost_cnt=0. If run=1 → WALK; gait is loaded from the sensor decode on the same edge, with lost loading FWD.
- WALK:
  - Prescaler counts 0..STEP_TICKS-1. At terminal count: step_tick=1 and step=(step==STEPS-1)?0:step+1.
  - The wrap edge (step STEPS-1→0) is the boundary. Sensors are sampled only there; gait is constant within a cycle.
  - Boundary with non-lost decode: gait ← decode, lost_cnt ← 0.
  - Boundary with lost: gait is kept and lost_cnt increments. If lost_cnt reaches LOST_CYCLES → SEARCH with gait=3.
- SEARCH: steps exactly as WALK with gait=3. At a boundary with any sensor=1 → WALK, gait ← decode, lost_cnt ← 0.
- run=0 in WALK/SEARCH → IDLE on the next edge, mid-cycle allowed. step, prescaler, gait and lost_cnt are cleared.
- addr = {gait, step} registered. Upper step bits are 0 when STEPS<64.

## Timing
- Reset (rst=0, async) values:
  - state INIT.
  - addr 0, gait 0, step 0, prescaler 0, init counter 0, lost_cnt 0.
  - l_en, r_en, c_en 0; step_tick 0.
- Reset asserted mid-operation clears everything asynchronously. The INIT hold restarts in full.
- state=IDLE on the edge ending cycle INIT_TICKS-1 after rst rises, i.e. exactly INIT_TICKS edges.
- IDLE→WALK: 1 edge after run=1 is sampled. Enables and addr update on that same edge.
- First step_tick occurs STEP_TICKS edges after entering WALK.
- step_tick, the addr change and a gait change are coincident on the same edge. A gait change appears together with step=0.
- All outputs are registered; no combinational path from inputs to outputs.
- run=0 at the same edge as a boundary: IDLE wins and the boundary is ignored.
- Gait cycle period = STEP_TICKS×STEPS clk.

## Test plan
Bench parameters for all cases: STEP_TICKS=4, INIT_TICKS=10, STEPS=8, LOST_CYCLES=2.
1. Release rst with run=1, sensors 11.
   → state INIT for 10 edges, IDLE for 1, then WALK. addr 0x00, l_en=r_en=c_en=1. step_tick every 4 clk; addr counts 0..7 and wraps to 0.
2. In WALK/FWD, set sensors 10 at step 3.
   → addr stays 0x0x until the wrap. At the wrap addr=0x40 with l_en=1, r_en=0. No change before the boundary.
3. Sensors 00 from FWD.
   → After 1 boundary: gait still 0, state WALK. After 2nd boundary: state SEARCH, addr=0xC0. Then sensors 01 → at next boundary state WALK, addr=0x80, l_en=0, r_en=1.
4. Drop run mid-cycle at step 5.
   → Next edge: state IDLE, addr 0, all enables 0, no step_tick. run=1 again → WALK after 1 edge, first tick after 4 clk.
5. Assert rst during SEARCH.
   → Outputs go to reset values without a clk edge. After release the full 10-cycle INIT repeats.
6. run falling on the same edge as a boundary with sensors 01.
   → state IDLE, addr 0, gait not updated.
